// File: rtl/rv32i_dmem_resp.sv
// Data-memory responder for the single-cycle RV32I core: word RAM in the low
// half of the address space, timer / tohost / bus-error MMIO in the high half.
module rv32i_dmem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        timer_irq,
   output logic        done,
   output logic [31:0] tohost,
   output logic        bus_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [7:0] OFF_MTIME    = 8'h00;
   localparam logic [7:0] OFF_MTIMECMP = 8'h04;
   localparam logic [7:0] OFF_CTRL     = 8'h08;
   localparam logic [7:0] OFF_TOHOST   = 8'h0C;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [31:0]      mtime;
   logic [31:0]      mtimecmp;
   logic             en;

   logic             misaligned;
   logic             is_mmio;
   logic [IDX_W-1:0] ram_idx;
   logic [7:0]       off;

   logic             ram_we;
   logic             wr_mtime;
   logic             wr_cmp;
   logic             wr_ctrl;
   logic             wr_tohost;
   logic             wr_bad;
   logic             irq_set;
   logic             irq_clr;

   // Address bits that play no part in decode (aliasing is intentional).
   logic             unused_bits;
   assign unused_bits = ^addr[30:8] ^ ^MMIO_BASE[30:0];

   assign misaligned = |addr[1:0];
   assign is_mmio    = (addr[31] == MMIO_BASE[31]);
   assign ram_idx    = addr[IDX_W+1:2];
   assign off        = addr[7:0];

   // Write strobe decode; misaligned writes reach no target.
   always_comb begin
      ram_we    = 1'b0;
      wr_mtime  = 1'b0;
      wr_cmp    = 1'b0;
      wr_ctrl   = 1'b0;
      wr_tohost = 1'b0;
      wr_bad    = 1'b0;
      if (we && !misaligned) begin
         if (!is_mmio) begin
            ram_we = 1'b1;
         end else begin
            case (off)
               OFF_MTIME:    wr_mtime  = 1'b1;
               OFF_MTIMECMP: wr_cmp    = 1'b1;
               OFF_CTRL:     wr_ctrl   = 1'b1;
               OFF_TOHOST:   wr_tohost = 1'b1;
               default:      wr_bad    = 1'b1;
            endcase
         end
      end
   end

   // Match uses the pre-increment count; clear is write-1 on CTRL bit1.
   always_comb begin
      irq_set = en && (mtime == mtimecmp);
      irq_clr = wr_ctrl && wdata[1];
   end

   // Combinational read mux; misaligned reads and unmapped offsets return 0.
   always_comb begin
      rdata = '0;
      if (!misaligned) begin
         if (!is_mmio) begin
            rdata = mem[ram_idx];
         end else begin
            case (off)
               OFF_MTIME:    rdata = mtime;
               OFF_MTIMECMP: rdata = mtimecmp;
               OFF_CTRL:     rdata = {31'b0, en};
               OFF_TOHOST:   rdata = tohost;
               default:      rdata = '0;
            endcase
         end
      end
   end

   // RAM write port; not reset, and a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (ram_we && rst_n) begin
         mem[ram_idx] <= wdata;
      end
   end

   // Timer: software load has priority over the free-running increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime    <= '0;
         mtimecmp <= '1;
         en       <= 1'b0;
      end else begin
         if (wr_mtime) begin
            mtime <= wdata;
         end else if (en) begin
            mtime <= mtime + 32'd1;
         end
         if (wr_cmp) begin
            mtimecmp <= wdata;
         end
         if (wr_ctrl) begin
            en <= wdata[0];
         end
      end
   end

   // Sticky timer interrupt; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_irq <= 1'b0;
      end else if (irq_set) begin
         timer_irq <= 1'b1;
      end else if (irq_clr) begin
         timer_irq <= 1'b0;
      end
   end

   // tohost captures only the first write after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tohost <= '0;
         done   <= 1'b0;
      end else if (wr_tohost && !done) begin
         tohost <= wdata;
         done   <= 1'b1;
      end
   end

   // Sticky error on misaligned writes and writes to unmapped MMIO offsets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_err <= 1'b0;
      end else if ((we && misaligned) || wr_bad) begin
         bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_resp.sv
// Bench for rv32i_dmem_resp: directed vectors, a spec-level reference model
// checked every cycle, and hand-computed literal checks.
module tb_rv32i_dmem_resp;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        timer_irq;
   logic        done;
   logic [31:0] tohost;
   logic        bus_err;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   rv32i_dmem_resp #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(32'h8000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .timer_irq(timer_irq), .done(done), .tohost(tohost),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_ram [int];
   logic [31:0] m_mtime, m_cmp, m_tohost;
   bit          m_en, m_irq, m_done, m_err;

   task automatic model_reset();
      m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0;
      m_irq = 0; m_done = 0; m_tohost = 0; m_err = 0;
   endtask

   // Returns 1 when the expected read value is known (RAM may be unwritten).
   function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
      int unsigned idx;
      v = 0;
      if (a % 4 != 0) return 1;
      if (a < 32'h8000_0000) begin
         idx = (a % (DEPTH * 4)) / 4;
         if (!m_ram.exists(idx)) return 0;
         v = m_ram[idx];
         return 1;
      end
      case (a & 32'hFF)
         0:  v = m_mtime;
         4:  v = m_cmp;
         8:  v = {31'b0, m_en};
         12: v = m_tohost;
         default: v = 0;
      endcase
      return 1;
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         logic [31:0] n_mtime, n_cmp;
         bit n_en, set, clr;
         set = m_en && (m_mtime == m_cmp);
         clr = 0;
         n_mtime = m_en ? m_mtime + 1 : m_mtime;
         n_cmp = m_cmp;
         n_en = m_en;
         if (we) begin
            if (addr % 4 != 0) m_err = 1;
            else if (addr < 32'h8000_0000) m_ram[(addr % (DEPTH * 4)) / 4] = wdata;
            else begin
               case (addr & 32'hFF)
                  0:  n_mtime = wdata;
                  4:  n_cmp = wdata;
                  8:  begin n_en = wdata[0]; clr = wdata[1]; end
                  12: if (!m_done) begin m_tohost = wdata; m_done = 1; end
                  default: m_err = 1;
               endcase
            end
         end
         m_irq = set ? 1'b1 : (clr ? 1'b0 : m_irq);
         m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on && rst_n) begin
         logic [31:0] ev;
         chk("cyc_irq", {31'b0, timer_irq}, {31'b0, m_irq});
         chk("cyc_done", {31'b0, done}, {31'b0, m_done});
         chk("cyc_tohost", tohost, m_tohost);
         chk("cyc_bus_err", {31'b0, bus_err}, {31'b0, m_err});
         if (model_read(addr, ev)) chk("cyc_rdata", rdata, ev);
      end
   end

   // Drive one cycle's inputs just after a rising edge.
   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      we = w; addr = a; wdata = d;
   endtask

   initial begin
      logic [31:0] r1;
      bit seen;
      we = 0; addr = 0; wdata = 0;
      rst_n = 0;
      model_reset();
      #2;
      chk("rst_irq", {31'b0, timer_irq}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_tohost", tohost, 32'd0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      #10 rst_n = 1;
      chk_on = 1;

      // RAM write/read, old value during write, aliasing
      drive(1, 32'h10, 32'h1111_1111);
      drive(1, 32'h10, 32'hDEAD_BEEF);
      #2 chk("ram_old_during_write", rdata, 32'h1111_1111);
      drive(0, 32'h10, 0);
      #2 chk("ram_read", rdata, 32'hDEAD_BEEF);
      drive(1, 32'h1010, 32'h1234);
      drive(0, 32'h10, 0);
      #2 chk("ram_alias", rdata, 32'h1234);

      // misaligned MMIO read: zero, no error
      drive(0, 32'h8000_0001, 0);
      #2 chk("mis_read_mmio", rdata, 32'd0);
      chk("mis_read_no_err", {31'b0, bus_err}, 32'd0);

      // TOHOST first-write latch
      drive(1, 32'h8000_000C, 32'h1);
      drive(0, 32'h8000_000C, 0);
      #2 chk("tohost_done", {31'b0, done}, 32'd1);
      chk("tohost_val", tohost, 32'd1);
      drive(1, 32'h8000_000C, 32'h99);
      drive(0, 32'h8000_000C, 0);
      #2 chk("tohost_hold", tohost, 32'd1);
      chk("tohost_no_err", {31'b0, bus_err}, 32'd0);

      // timer compare / IRQ
      drive(1, 32'h8000_0004, 32'd5);
      drive(1, 32'h8000_0008, 32'd1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         drive(0, 32'h8000_0000, 0);
         #2 if (timer_irq) begin
            seen = 1;
            chk("irq_mtime_at_rise", rdata, 32'd6);
         end
      end
      chk("irq_seen", {31'b0, seen}, 32'd1);
      drive(0, 32'h8000_0000, 0);
      #2 chk("irq_sticky", {31'b0, timer_irq}, 32'd1);
      drive(1, 32'h8000_0008, 32'd3);
      drive(0, 32'h8000_0000, 0);
      #2 chk("irq_cleared", {31'b0, timer_irq}, 32'd0);
      r1 = rdata;
      drive(0, 32'h8000_0000, 0);
      #2 chk("mtime_counting", rdata, r1 + 32'd1);
      drive(1, 32'h8000_0000, 32'hFFFF_FFFE);
      drive(0, 32'h8000_0000, 0);
      drive(0, 32'h8000_0000, 0);
      drive(0, 32'h8000_0000, 0);
      #2 chk("mtime_wrap", rdata, 32'd0);

      // misaligned write: no RAM change, sticky error
      drive(1, 32'h12, 32'hAAAA_AAAA);
      drive(0, 32'h12, 0);
      #2 chk("mis_wr_err", {31'b0, bus_err}, 32'd1);
      chk("mis_read_ram", rdata, 32'd0);
      drive(0, 32'h10, 0);
      #2 chk("mis_wr_no_ram", rdata, 32'h1234);

      // force IRQ, then reset mid-cycle with a write in flight
      drive(1, 32'h8000_0004, 32'd0);
      drive(1, 32'h8000_0000, 32'd0);
      drive(0, 32'h8000_0000, 0);
      drive(0, 32'h8000_0000, 0);
      #2 chk("pre_rst_irq", {31'b0, timer_irq}, 32'd1);
      drive(1, 32'h8000_0004, 32'h77);
      #2 rst_n = 0;
      model_reset();
      we = 0;
      #1;
      chk("mrst_irq", {31'b0, timer_irq}, 32'd0);
      chk("mrst_done", {31'b0, done}, 32'd0);
      chk("mrst_tohost", tohost, 32'd0);
      chk("mrst_bus_err", {31'b0, bus_err}, 32'd0);
      chk("mrst_cmp", rdata, 32'hFFFF_FFFF);
      #8 rst_n = 1;
      drive(0, 32'h8000_0000, 0);
      drive(0, 32'h8000_0000, 0);
      #2 chk("mrst_mtime_hold", rdata, 32'd0);

      // unmapped MMIO offset
      drive(1, 32'h8000_0040, 32'd5);
      drive(0, 32'h8000_0040, 0);
      #2 chk("bad_off_err", {31'b0, bus_err}, 32'd1);
      chk("bad_off_read", rdata, 32'd0);
      drive(0, 32'h8000_0004, 0);
      #2 chk("bad_off_cmp", rdata, 32'hFFFF_FFFF);
      drive(0, 32'h8000_0000, 0);
      #2 chk("bad_off_mtime", rdata, 32'd0);
      chk("bad_off_done", {31'b0, done}, 32'd0);

      drive(0, 32'h10, 0);
      @(posedge clk);
      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rv32i_dmem_resp.md
Name: rv32i_dmem_resp

Overview:
Data-memory responder for the single-cycle RV32I core. It sits on the core's data port, with address = ALUResult, wdata = WriteData, we = MemWrite and rdata = ReadData. It serves word-wide RAM in the low half of the address space. It also serves a small MMIO block in the high half: a free-running timer with compare/IRQ, a test-completion (tohost) register and a sticky bus-error flag.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two, at least 4.
MMIO_BASE, 32'h8000_0000, base of the MMIO window. Decode is on addr[31] only.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write strobe (core MemWrite), sampled at rising clk
addr  in  32  byte address (core ALUResult)
wdata  in  32  write data (core WriteData)
rdata  out  32  read data (core ReadData), combinational from addr
timer_irq  out  1  registered timer interrupt flag, sticky
done  out  1  registered; set by first TOHOST write
tohost  out  32  registered value latched by first TOHOST write
bus_err  out  1  registered sticky error flag

Behaviour:
- Reset (async, rst_n=0) sets the following immediately, regardless of clk:
  - mtime=0, mtimecmp=32'hFFFF_FFFF, ctrl=0
  - timer_irq=0, done=0, tohost=0, bus_err=0
  - RAM contents are not reset (undefined until written).
- Region select: addr[31]=0 is RAM; addr[31]=1 is MMIO.
- Misaligned access (addr[1:0]!=0), either region:
  - rdata=0 and any write is suppressed.
  - If we=1, bus_err is set at the edge. A misaligned read does not set bus_err.
- RAM:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses alias.
  - Read is asynchronous: rdata = mem[index] in the same cycle.
  - Write: mem[index] <= wdata at the rising edge when we=1.
  - Same-cycle write and read of one word: rdata shows the old value until the edge.
- MMIO registers (offset = addr[7:0]; addr[30:8] ignored):
  - 0x00 MTIME: R/W. A write loads wdata and takes priority over that cycle's increment.
  - 0x04 MTIMECMP: R/W.
  - 0x08 CTRL: bit0 EN is R/W. bit1 IRQ_CLR is write-1-to-clear of timer_irq and always reads 0. Other bits read 0.
  - 0x0C TOHOST: reads the current tohost. A write latches it only if done=0 (see TOHOST below).
  - Any other offset: reads 0, writes ignored; a write sets bus_err.
- Timer:
  - mtime increments by 1 every cycle while EN=1 and holds while EN=0.
  - It wraps 32'hFFFF_FFFF -> 0 with no flag.
- Timer IRQ:
  - At each edge, if EN=1 and the current (pre-increment) mtime == mtimecmp, timer_irq <= 1.
  - A write of CTRL with bit1=1 clears timer_irq.
  - Set and clear in the same cycle: set wins.
  - timer_irq is otherwise sticky. Clearing EN does not clear it.
- TOHOST:
  - A write while done=0 latches tohost <= wdata and done <= 1 at the edge.
  - Writes while done=1 are ignored and are not errors.
  - done clears only on reset.
- bus_err: sticky until reset.
- Reset asserted mid-operation: all registers return to reset values immediately; a write in the same cycle is lost.
- Latency summary:
  - reads: 0 cycles (combinational)
  - writes and register updates: visible the cycle after the edge
  - timer_irq: one edge after the match cycle

Test Plan:
1. RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> rdata=0xDEADBEEF. Same-cycle read during that write -> old value. With DEPTH_WORDS=1024, write 0x1234 to 0x0000_1010 -> read 0x10 returns 0x1234 (aliasing).
2. Misalignment:
   - write to 0x0000_0012 -> no RAM change; bus_err=1 next cycle.
   - read 0x0000_0012 -> rdata=0.
   - read 0x8000_0001 -> rdata=0 and bus_err unaffected.
3. Timer:
   - write MTIMECMP=5, CTRL=1 with mtime=0 -> timer_irq rises after the edge where mtime=5, then stays 1.
   - write CTRL=3 -> timer_irq=0 next cycle; mtime keeps counting.
   - write MTIME=0xFFFF_FFFE -> after 2 cycles, rdata @0x8000_0000 = 0.
4. TOHOST: write 0x1 to 0x8000_000C -> done=1, tohost=1. Subsequent write of 0x99 -> tohost stays 1, bus_err stays 0.
5. Bad offset: write to 0x8000_0040 -> bus_err=1; read 0x8000_0040 -> 0; no other register changes.
6. Reset: set EN=1, let timer_irq=1, done=1, then pulse rst_n low mid-cycle -> all outputs 0 immediately, MTIMECMP reads 0xFFFF_FFFF, mtime holds at 0 after release.
